// File: rtl/riscv32_imem_loader_pkg.sv
// Shared definitions for the boot-time IMEM loader: FSM state encoding and
// byte/word geometry of the incoming little-endian stream.
package riscv32_loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RECV  = 3'd1,
      ST_WRITE = 3'd2,
      ST_DONE  = 3'd3,
      ST_ERR   = 3'd4
   } loader_state_e;

   localparam int LOADER_BYTES_PER_WORD = 4;
   localparam int LOADER_IDX_W          = $clog2(LOADER_BYTES_PER_WORD);

endpackage

// File: rtl/riscv32_imem_loader_byte_to_word.sv
// Assembles four little-endian bytes into a 32-bit word; word_valid pulses
// alongside the byte that completes the word.
module riscv32_byte_to_word
   import riscv32_loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic        byte_en,
   input  logic [7:0]  byte_data,
   output logic [31:0] word,
   output logic        word_valid
);

   localparam logic [LOADER_IDX_W-1:0] LAST_IDX = LOADER_IDX_W'(LOADER_BYTES_PER_WORD - 1);

   logic [LOADER_IDX_W-1:0] idx_q, idx_d;
   logic [31:0]             word_q, word_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         idx_q  <= '0;
         word_q <= '0;
      end else begin
         idx_q  <= idx_d;
         word_q <= word_d;
      end
   end

   // The index wraps to 0 after the last lane, so a completed word leaves it
   // ready for the next one without an explicit clear.
   always_comb begin
      idx_d  = idx_q;
      word_d = word_q;
      if (clear) begin
         idx_d = '0;
      end else if (byte_en) begin
         word_d[{idx_q, 3'b000} +: 8] = byte_data;
         idx_d                        = idx_q + 1'b1;
      end
   end

   assign word       = word_q;
   assign word_valid = byte_en & (idx_q == LAST_IDX);

endmodule

// File: rtl/riscv32_imem_loader.sv
// Boot loader: streams bytes into IMEM from word 0 and holds the RV32I core
// in reset until the requested number of words has been committed.
module riscv32_imem_loader
   import riscv32_loader_pkg::*;
#(
   parameter int IMEM_DEPTH_WORDS = 4096,
   parameter int ADDR_W           = $clog2(IMEM_DEPTH_WORDS),
   parameter int CNT_W            = ADDR_W + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_start,
   input  logic [CNT_W-1:0]  word_count,
   input  logic              s_valid,
   input  logic [7:0]        s_data,
   output logic              s_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              core_rst_n,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [CNT_W-1:0]  words_written,
   output logic [31:0]       checksum,
   output logic [2:0]        state_dbg
);

   // Stream handshake: a byte transfers on a rising edge where s_valid and
   // s_ready are both high; s_ready depends on state only, never on s_valid.

   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(IMEM_DEPTH_WORDS);

   loader_state_e    state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [CNT_W-1:0] ww_q, ww_d;
   logic [31:0]      csum_q, csum_d;
   logic             b2w_clear;
   logic             hs;
   logic             word_valid;
   logic [31:0]      asm_word;

   assign hs = s_valid & (state_q == ST_RECV);

   riscv32_byte_to_word u_b2w (
      .clk        (clk),
      .rst        (rst),
      .clear      (b2w_clear),
      .byte_en    (hs),
      .byte_data  (s_data),
      .word       (asm_word),
      .word_valid (word_valid)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         count_q <= '0;
         ww_q    <= '0;
         csum_q  <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         ww_q    <= ww_d;
         csum_q  <= csum_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      ww_d      = ww_q;
      csum_d    = csum_q;
      b2w_clear = 1'b0;
      unique case (state_q)
         ST_IDLE, ST_DONE, ST_ERR: begin
            if (load_start) begin
               if (word_count == '0) begin
                  state_d = ST_DONE;
               end else if (word_count > DEPTH_C) begin
                  state_d = ST_ERR;
               end else begin
                  state_d   = ST_RECV;
                  count_d   = word_count;
                  ww_d      = '0;
                  csum_d    = '0;
                  b2w_clear = 1'b1;
               end
            end
         end
         ST_RECV: begin
            if (word_valid) state_d = ST_WRITE;
         end
         ST_WRITE: begin
            ww_d    = ww_q + CNT_W'(1);
            csum_d  = csum_q ^ asm_word;
            state_d = (ww_d == count_q) ? ST_DONE : ST_RECV;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      s_ready       = (state_q == ST_RECV);
      imem_we       = (state_q == ST_WRITE);
      imem_addr     = ww_q[ADDR_W-1:0];
      imem_wdata    = asm_word;
      core_rst_n    = (state_q == ST_DONE);
      busy          = (state_q == ST_RECV) || (state_q == ST_WRITE);
      done          = (state_q == ST_DONE);
      error         = (state_q == ST_ERR);
      words_written = ww_q;
      checksum      = csum_q;
      state_dbg     = state_q;
   end

endmodule

// File: tb/tb_riscv32_imem_loader.sv
// Directed bench for riscv32_imem_loader: normal, gapped, zero-count, overflow,
// reload and mid-load reset scenarios against hand-computed IMEM writes.
`timescale 1ns/1ps
module tb_riscv32_imem_loader;

   logic        clk = 1'b0;
   logic        rst, load_start, s_valid;
   logic [12:0] word_count;
   logic [7:0]  s_data;
   logic        s_ready, imem_we, core_rst_n, busy, done, error;
   logic [11:0] imem_addr;
   logic [31:0] imem_wdata, checksum;
   logic [12:0] words_written;
   logic [2:0]  state_dbg;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          viol  = 0;
   logic [11:0] wr_addr_q[$];
   logic [31:0] wr_data_q[$];

   riscv32_imem_loader dut (
      .clk(clk), .rst(rst), .load_start(load_start), .word_count(word_count),
      .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready), .imem_we(imem_we),
      .imem_addr(imem_addr), .imem_wdata(imem_wdata), .core_rst_n(core_rst_n),
      .busy(busy), .done(done), .error(error), .words_written(words_written),
      .checksum(checksum), .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time exceeded, got timeout expected finish");
      $fatal(1);
   end

   // IMEM write log; a write is only legal in WRITE with s_ready low.
   always @(negedge clk) begin
      if (imem_we === 1'b1) begin
         wr_addr_q.push_back(imem_addr);
         wr_data_q.push_back(imem_wdata);
         if (s_ready !== 1'b0 || state_dbg !== 3'd2) viol++;
      end
   end

   task automatic start_load(input logic [12:0] wc);
      load_start = 1'b1; word_count = wc;
      @(negedge clk);
      load_start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int t;
      s_valid = 1'b1; s_data = b; t = 0;
      while (s_ready !== 1'b1 && t < 50) begin @(negedge clk); t++; end
      if (t >= 50) begin
         n_cmp++; n_bad++;
         $display("FAIL send_byte_timeout: s_ready got %b expected 1", s_ready);
      end
      @(negedge clk);
      s_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w, input bit gaps);
      for (int i = 0; i < 4; i++) begin
         if (gaps) repeat ($urandom_range(0, 5)) @(negedge clk);
         send_byte(w[8*i +: 8]);
      end
   endtask

   task automatic wait_done(input string name);
      int t;
      t = 0;
      while (done !== 1'b1 && t < 40) begin @(negedge clk); t++; end
      n_cmp++;
      if (done !== 1'b1) begin n_bad++; $display("FAIL %s_wait_done: done got %b expected 1", name, done); end
   endtask

   task automatic test_reset();
      rst = 1'b1; load_start = 1'b0; word_count = '0; s_valid = 1'b0; s_data = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      n_cmp++; if (state_dbg !== 3'd0) begin n_bad++; $display("FAIL reset_state: got %0d expected 0", state_dbg); end
      n_cmp++; if (s_ready !== 1'b0) begin n_bad++; $display("FAIL reset_s_ready: got %b expected 0", s_ready); end
      n_cmp++; if (imem_we !== 1'b0) begin n_bad++; $display("FAIL reset_imem_we: got %b expected 0", imem_we); end
      n_cmp++; if (imem_addr !== 12'd0) begin n_bad++; $display("FAIL reset_imem_addr: got %h expected 0", imem_addr); end
      n_cmp++; if (imem_wdata !== 32'd0) begin n_bad++; $display("FAIL reset_imem_wdata: got %h expected 0", imem_wdata); end
      n_cmp++; if (core_rst_n !== 1'b0) begin n_bad++; $display("FAIL reset_core_rst_n: got %b expected 0", core_rst_n); end
      n_cmp++; if ({busy, done, error} !== 3'b000) begin n_bad++; $display("FAIL reset_flags: got %b expected 000", {busy, done, error}); end
      n_cmp++; if (words_written !== 13'd0) begin n_bad++; $display("FAIL reset_words_written: got %0d expected 0", words_written); end
      n_cmp++; if (checksum !== 32'd0) begin n_bad++; $display("FAIL reset_checksum: got %h expected 0", checksum); end
   endtask

   task automatic test_zero();
      wr_addr_q.delete(); wr_data_q.delete();
      start_load(13'd0);
      n_cmp++; if (state_dbg !== 3'd3) begin n_bad++; $display("FAIL zero_state: got %0d expected 3", state_dbg); end
      n_cmp++; if (done !== 1'b1 || core_rst_n !== 1'b1) begin n_bad++; $display("FAIL zero_done: got %b%b expected 11", done, core_rst_n); end
      n_cmp++; if (checksum !== 32'd0) begin n_bad++; $display("FAIL zero_checksum: got %h expected 0", checksum); end
      @(negedge clk);
      n_cmp++; if (wr_addr_q.size() !== 0) begin n_bad++; $display("FAIL zero_writes: got %0d expected 0", wr_addr_q.size()); end
   endtask

   task automatic check_three(input string name);
      logic [31:0] exp_w[3];
      logic [31:0] exp_sum;
      exp_w[0] = 32'h0000_0013; exp_w[1] = 32'h00a0_0093; exp_w[2] = 32'h0140_0113;
      exp_sum = exp_w[0] ^ exp_w[1] ^ exp_w[2];
      n_cmp++; if (wr_addr_q.size() !== 3) begin n_bad++; $display("FAIL %s_write_count: got %0d expected 3", name, wr_addr_q.size()); end
      for (int i = 0; i < 3; i++) begin
         n_cmp++;
         if (wr_addr_q.size() > i && (wr_addr_q[i] !== 12'(i) || wr_data_q[i] !== exp_w[i])) begin
            n_bad++;
            $display("FAIL %s_write%0d: got (%0d,%h) expected (%0d,%h)", name, i, wr_addr_q[i], wr_data_q[i], i, exp_w[i]);
         end
      end
      n_cmp++; if (checksum !== exp_sum) begin n_bad++; $display("FAIL %s_checksum: got %h expected %h", name, checksum, exp_sum); end
      n_cmp++; if (words_written !== 13'd3) begin n_bad++; $display("FAIL %s_words_written: got %0d expected 3", name, words_written); end
      n_cmp++; if (core_rst_n !== 1'b1) begin n_bad++; $display("FAIL %s_core_rst_n: got %b expected 1", name, core_rst_n); end
   endtask

   task automatic test_normal();
      logic [7:0] bytes[12] = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'ha0, 8'h00, 8'h13, 8'h01, 8'h40, 8'h01};
      wr_addr_q.delete(); wr_data_q.delete();
      start_load(13'd3);
      n_cmp++; if (busy !== 1'b1 || core_rst_n !== 1'b0) begin n_bad++; $display("FAIL normal_busy: got %b%b expected 10", busy, core_rst_n); end
      for (int i = 0; i < 12; i++) send_byte(bytes[i]);
      n_cmp++; if (imem_we !== 1'b1 || s_ready !== 1'b0 || imem_addr !== 12'd2) begin
         n_bad++; $display("FAIL normal_write_cycle: got we=%b rdy=%b addr=%0d expected we=1 rdy=0 addr=2", imem_we, s_ready, imem_addr);
      end
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL normal_done_early: got %b expected 0", done); end
      @(negedge clk);
      n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL normal_done_latency: got %b expected 1", done); end
      check_three("normal");
   endtask

   task automatic test_gaps();
      wr_addr_q.delete(); wr_data_q.delete();
      start_load(13'd3);
      send_word(32'h0000_0013, 1'b1);
      send_word(32'h00a0_0093, 1'b1);
      send_word(32'h0140_0113, 1'b1);
      wait_done("gaps");
      @(negedge clk);
      check_three("gaps");
   endtask

   task automatic test_err();
      wr_addr_q.delete(); wr_data_q.delete();
      start_load(13'd4097);
      n_cmp++; if (error !== 1'b1 || state_dbg !== 3'd4) begin n_bad++; $display("FAIL err_state: got err=%b st=%0d expected err=1 st=4", error, state_dbg); end
      n_cmp++; if (core_rst_n !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL err_core_rst: got %b%b expected 00", core_rst_n, done); end
      repeat (3) @(negedge clk);
      n_cmp++; if (wr_addr_q.size() !== 0 || error !== 1'b1) begin n_bad++; $display("FAIL err_no_write: got %0d writes err=%b expected 0 writes err=1", wr_addr_q.size(), error); end
      start_load(13'd4096);
      n_cmp++; if (state_dbg !== 3'd1) begin n_bad++; $display("FAIL err_full_depth_accept: got %0d expected 1", state_dbg); end
      rst = 1'b1; @(negedge clk); rst = 1'b0;
      start_load(13'd1);
      send_word(32'h0bad_f00d, 1'b0);
      wait_done("err_reload");
      @(negedge clk);
      n_cmp++; if (wr_addr_q.size() !== 1 || wr_addr_q[0] !== 12'd0 || wr_data_q[0] !== 32'h0bad_f00d) begin
         n_bad++; $display("FAIL err_reload_write: got %0d writes first=(%0d,%h) expected 1 write (0,0badf00d)", wr_addr_q.size(), wr_addr_q[0], wr_data_q[0]);
      end
      n_cmp++; if (checksum !== 32'h0bad_f00d || words_written !== 13'd1) begin
         n_bad++; $display("FAIL err_reload_counters: got sum=%h ww=%0d expected sum=0badf00d ww=1", checksum, words_written);
      end
   endtask

   task automatic test_reload_ignore();
      logic [31:0] w0, w1;
      w0 = 32'h4433_2211; w1 = 32'h8877_6655;
      wr_addr_q.delete(); wr_data_q.delete();
      start_load(13'd2);
      n_cmp++; if (core_rst_n !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL reload_rearm: got rst_n=%b busy=%b expected rst_n=0 busy=1", core_rst_n, busy); end
      n_cmp++; if (words_written !== 13'd0 || checksum !== 32'd0) begin n_bad++; $display("FAIL reload_clear: got ww=%0d sum=%h expected 0/0", words_written, checksum); end
      send_byte(w0[7:0]); send_byte(w0[15:8]);
      start_load(13'd5);
      n_cmp++; if (state_dbg !== 3'd1) begin n_bad++; $display("FAIL reload_ignore_recv: got %0d expected 1", state_dbg); end
      send_byte(w0[23:16]); send_byte(w0[31:24]);
      start_load(13'd0);
      n_cmp++; if (state_dbg !== 3'd1 || words_written !== 13'd1) begin n_bad++; $display("FAIL reload_ignore_write: got st=%0d ww=%0d expected st=1 ww=1", state_dbg, words_written); end
      send_word(w1, 1'b0);
      wait_done("reload");
      @(negedge clk);
      n_cmp++; if (words_written !== 13'd2 || checksum !== (w0 ^ w1)) begin n_bad++; $display("FAIL reload_counters: got ww=%0d sum=%h expected ww=2 sum=%h", words_written, checksum, w0 ^ w1); end
      n_cmp++; if (wr_addr_q.size() !== 2 || wr_data_q[0] !== w0 || wr_data_q[1] !== w1 || wr_addr_q[1] !== 12'd1) begin
         n_bad++; $display("FAIL reload_writes: got %0d writes d0=%h d1=%h expected 2 writes d0=%h d1=%h", wr_addr_q.size(), wr_data_q[0], wr_data_q[1], w0, w1);
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] w0;
      w0 = 32'hcafe_1234;
      wr_addr_q.delete(); wr_data_q.delete();
      start_load(13'd2);
      send_word(w0, 1'b0);
      send_byte(8'h55); send_byte(8'h66);
      rst = 1'b1; load_start = 1'b1; word_count = 13'd1;
      @(negedge clk);
      rst = 1'b0; load_start = 1'b0;
      n_cmp++; if (state_dbg !== 3'd0 || busy !== 1'b0) begin n_bad++; $display("FAIL midrst_state: got st=%0d busy=%b expected st=0 busy=0", state_dbg, busy); end
      n_cmp++; if (words_written !== 13'd0 || core_rst_n !== 1'b0) begin n_bad++; $display("FAIL midrst_counters: got ww=%0d rst_n=%b expected 0/0", words_written, core_rst_n); end
      n_cmp++; if (wr_addr_q.size() !== 1 || wr_addr_q[0] !== 12'd0 || wr_data_q[0] !== w0) begin
         n_bad++; $display("FAIL midrst_writes: got %0d writes first=(%0d,%h) expected 1 write (0,%h)", wr_addr_q.size(), wr_addr_q[0], wr_data_q[0], w0);
      end
      wr_addr_q.delete(); wr_data_q.delete();
      start_load(13'd1);
      send_word(32'hdead_beef, 1'b0);
      wait_done("midrst_reload");
      @(negedge clk);
      n_cmp++; if (wr_addr_q.size() !== 1 || wr_addr_q[0] !== 12'd0 || wr_data_q[0] !== 32'hdead_beef) begin
         n_bad++; $display("FAIL midrst_reload_write: got %0d writes first=(%0d,%h) expected 1 write (0,deadbeef)", wr_addr_q.size(), wr_addr_q[0], wr_data_q[0]);
      end
   endtask

   initial begin
      test_reset();
      test_zero();
      test_normal();
      test_gaps();
      test_err();
      test_reload_ignore();
      test_reset_mid();
      n_cmp++; if (viol !== 0) begin n_bad++; $display("FAIL write_only_in_write_state: got %0d bad writes expected 0", viol); end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/riscv32_imem_loader.md
# riscv32_imem_loader

Boot-time program loader sitting directly upstream of the RV32I single-cycle core's instruction memory. It accepts a little-endian byte stream over a valid/ready handshake, assembles 32-bit words, and writes them sequentially into IMEM from word address 0. It holds the core in reset until the requested number of words has been written, then releases it. This replaces simulation-only `$readmemh` preloading with a synthesizable path.

## Interface
Parameters:
- `IMEM_DEPTH_WORDS`, default 4096: IMEM capacity in words. Must match the core's IMEM.
- `ADDR_W`, default `$clog2(IMEM_DEPTH_WORDS)`: width of the IMEM word address.
- `CNT_W`, default `ADDR_W+1`: width of word counters, so a full-depth count is representable.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `load_start` in 1: one-cycle pulse that begins a load. Honoured only in IDLE, DONE and ERR.
- `word_count` in CNT_W: number of words to load. Sampled on an accepted `load_start`.
- `s_valid` in 1: byte stream valid.
- `s_data` in 8: byte stream data, least-significant byte of each word first.
- `s_ready` out 1: loader can accept a byte.
- `imem_we` out 1: IMEM write enable.
- `imem_addr` out ADDR_W: IMEM word address.
- `imem_wdata` out 32: IMEM write data.
- `core_rst_n` out 1: active-low reset to the core. It is 1 only in DONE.
- `busy` out 1: high in RECV and WRITE.
- `done` out 1: high in DONE.
- `error` out 1: high in ERR.
- `words_written` out CNT_W: number of words committed in the current or last load.
- `checksum` out 32: XOR of all words committed in the current or last load.

## Operation
States are IDLE, RECV, WRITE, DONE and ERR.

- **IDLE**: entered on reset.
  - On `load_start`:
    - `word_count == 0` → DONE.
    - `word_count > IMEM_DEPTH_WORDS` → ERR.
    - Otherwise → RECV. Latch `word_count`, and clear `words_written`, `checksum` and the 2-bit byte index.
- **RECV**: `s_ready` = 1.
  - Each `s_valid & s_ready` handshake stores `s_data` into byte lane `[8*idx +: 8]` of the assembly register, then increments `idx`.
  - On the handshake with `idx == 3` → WRITE.
  - `load_start` is ignored in RECV and WRITE.
- **WRITE**: lasts exactly one cycle.
  - Outputs: `s_ready` = 0, `imem_we` = 1, `imem_addr` = `words_written[ADDR_W-1:0]`, `imem_wdata` = the assembled word.
  - On exit: `words_written` += 1, `checksum` ^= the word, `idx` = 0.
  - If the new `words_written` equals the latched count → DONE, else → RECV.
- **DONE**: `core_rst_n` = 1.
  - `load_start` re-arms with the same rules as IDLE. `core_rst_n` drops in the cycle after the accepted pulse.
- **ERR**: `core_rst_n` = 0 and no IMEM writes.
  - `load_start` re-arms with the same rules as IDLE.

Counter width: `words_written` never exceeds `IMEM_DEPTH_WORDS`, so the address never wraps. The full-depth count (4096) writes addresses 0..4095.

## Timing
- Reset values:
  - State IDLE; `s_ready` = 0, `imem_we` = 0.
  - `imem_addr` = 0, `imem_wdata` = 0.
  - `core_rst_n` = 0; `busy` = `done` = `error` = 0.
  - `words_written` = 0, `checksum` = 0.
- All outputs are registered or decoded from state only. There are no combinational paths from `s_valid` to `s_ready`.
- Latency:
  - A word is written one cycle after its 4th byte handshake.
  - With no stalls, the minimum is 5 cycles per word.
  - `done` asserts in the cycle after the final WRITE cycle.
- Backpressure: `s_valid` may drop at any time. Partial words are held indefinitely.
- Reset mid-load: state returns to IDLE and any partial word is discarded. Words already written stay in IMEM, and `core_rst_n` returns to 0.
- A `load_start` coincident with `rst` is ignored.

## Structure
- A shared package `riscv32_loader_pkg` holds the state enum localparams (IDLE=0, RECV=1, WRITE=2, DONE=3, ERR=4) and `LOADER_BYTES_PER_WORD = 4`.
- One natural sub-module: `riscv32_byte_to_word`, the byte-index counter plus 32-bit assembly register, with a `word_valid` pulse on the 4th byte. The FSM and counters stay in the top.
- Integration: `imem_*` drives a new write port on the core's IMEM, and `core_rst_n` gates the core reset.

## Test plan
- **Normal 3-word load**:
  - Stimulus: `word_count` = 3, byte stream 13 00 00 00 93 00 a0 00 13 01 40 01.
  - Response: writes (0, 00000013), (1, 00a00093), (2, 01400113); `checksum` = 0140_0193 ^ 00a0_0000 = 01e0_0193 (recompute in the bench); `done` = 1, `core_rst_n` = 1, `words_written` = 3.
- **Random `s_valid` gaps** (0–5 idle cycles):
  - Response: identical IMEM contents and checksum.
  - No `imem_we` except in WRITE; `s_ready` = 0 in each WRITE cycle.
- **`word_count` = 0**:
  - Response: DONE in the next cycle, no writes, `checksum` = 0.
- **`word_count` = 4097**:
  - Response: ERR; `error` = 1, `core_rst_n` = 0, no `imem_we`.
  - A following `load_start` with count 1 loads normally.
- **Reset mid-load**:
  - Stimulus: assert `rst` after 6 bytes of a 2-word load.
  - Response: IDLE, `words_written` = 0, only address 0 written.
  - A re-load then writes fresh data to address 0.
- **Reload from DONE**:
  - Stimulus: `load_start` in DONE.
  - Response: `core_rst_n` = 0 next cycle; `load_start` pulses during RECV have no effect.
